// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state/owner types and default widths for the run controller
package run_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    typedef enum logic {OWN_HOST, OWN_CORE} owner_t;

    localparam int PC_W  = 10;
    localparam int DM_AW = 8;
    localparam int DM_DW = 8;
    localparam int CYC_W = 24;

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host-side job handshake and host data-memory bus
interface run_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);

    logic          start;
    logic          halt;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_drop;

    modport master (
        output start, host_we, host_addr, host_wdata,
        input  halt, host_drop
    );

    modport slave (
        input  start, host_we, host_addr, host_wdata,
        output halt, host_drop
    );

endinterface

// File: rtl/run_ctrl_dmem_port_mux.sv
// dmem_port_mux: owner-selected host/core data-memory port with write masking and drop detection
module dmem_port_mux
    import run_ctrl_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  owner_t        owner,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          drop
);

    // Route the owner's port to memory; a host write while the core owns memory is flagged, not performed
    always_comb begin
        dm_we    = (owner == OWN_CORE) ? core_we    : host_we;
        dm_addr  = (owner == OWN_CORE) ? core_addr  : host_addr;
        dm_wdata = (owner == OWN_CORE) ? core_wdata : host_wdata;
        drop     = (owner == OWN_CORE) && host_we;
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: holds the core in load while start is high, runs it to a halt instruction, then hands
// data memory back to the host. Optional run watchdog enabled by macro RUN_CTRL_WATCHDOG_EN.
module run_ctrl #(
    parameter int               PC_W     = run_ctrl_pkg::PC_W,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int               DM_AW    = run_ctrl_pkg::DM_AW,
    parameter int               DM_DW    = run_ctrl_pkg::DM_DW,
    parameter int               CYC_W    = run_ctrl_pkg::CYC_W,
    parameter logic [CYC_W-1:0] WDOG_MAX = 24'hFF_FFFF
) (
    input  logic             CLK,
    input  logic             RST_N,
    run_ctrl_if.slave        bus,
    input  logic             halt_instr,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_init,
    output logic             core_en,
    input  logic             core_we,
    input  logic [DM_AW-1:0] core_addr,
    input  logic [DM_DW-1:0] core_wdata,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic [DM_DW-1:0] dm_wdata,
    output logic [CYC_W-1:0] run_cycles
`ifdef RUN_CTRL_WATCHDOG_EN
    ,
    output logic             timeout
`endif
);

    import run_ctrl_pkg::*;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    state_t           state;
    owner_t           owner;
    logic             drop;
    logic [CYC_W-1:0] cyc_nxt;
    logic             wd_hit;

    assign pc_init = RESET_PC;
    assign cyc_nxt = (&run_cycles) ? run_cycles : run_cycles + 1'b1;
    assign wd_hit  = WDOG && (cyc_nxt == WDOG_MAX);

    dmem_port_mux #(.AW(DM_AW), .DW(DM_DW)) u_mux (
        .owner      (owner),
        .host_we    (bus.host_we),
        .host_addr  (bus.host_addr),
        .host_wdata (bus.host_wdata),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .drop       (drop)
    );

    // Job FSM: start always wins and re-enters LOAD; outputs and memory owner are set with the transition
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            owner        <= OWN_HOST;
            bus.halt     <= 1'b0;
            bus.host_drop <= 1'b0;
            pc_load      <= 1'b1;
            core_en      <= 1'b0;
            run_cycles   <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout      <= 1'b0;
`endif
        end else begin
            bus.host_drop <= drop;
            if (bus.start) begin
                state      <= LOAD;
                owner      <= OWN_HOST;
                bus.halt   <= 1'b0;
                pc_load    <= 1'b1;
                core_en    <= 1'b0;
                run_cycles <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
                timeout    <= 1'b0;
`endif
            end else if (state == LOAD) begin
                state   <= RUN;
                owner   <= OWN_CORE;
                pc_load <= 1'b0;
                core_en <= 1'b1;
            end else if (state == RUN) begin
                run_cycles <= cyc_nxt;
                if (halt_instr || wd_hit) begin
                    state    <= DONE;
                    owner    <= OWN_HOST;
                    bus.halt <= 1'b1;
                    pc_load  <= 1'b1;
                    core_en  <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
                    timeout  <= wd_hit;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl
module tb_run_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        halt_instr;
    logic        pc_load;
    logic [9:0]  pc_init;
    logic        core_en;
    logic        core_we;
    logic [7:0]  core_addr;
    logic [7:0]  core_wdata;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic [23:0] run_cycles;
`ifdef RUN_CTRL_WATCHDOG_EN
    logic        timeout;
`endif

    logic [7:0]  mem [256];
    int          errors = 0;
    int          checks = 0;
    int          en_cnt;

    run_ctrl_if #(.AW(8), .DW(8)) bus ();

    run_ctrl #(.WDOG_MAX(24'd100)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .bus        (bus),
        .halt_instr (halt_instr),
        .pc_load    (pc_load),
        .pc_init    (pc_init),
        .core_en    (core_en),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .run_cycles (run_cycles)
`ifdef RUN_CTRL_WATCHDOG_EN
        ,
        .timeout    (timeout)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (dm_we) mem[dm_addr] <= dm_wdata;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        RST_N = 1'b1;
        bus.start = 1'b0;
        bus.host_we = 1'b0;
        bus.host_addr = 8'h00;
        bus.host_wdata = 8'h00;
        halt_instr = 1'b0;
        core_we = 1'b1;
        core_addr = 8'h03;
        core_wdata = 8'h55;
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_pc_load", pc_load, 1);
        chk("rst_core_en", core_en, 0);
        chk("rst_halt", bus.halt, 0);
        chk("rst_cycles", run_cycles, 0);
        chk("rst_drop", bus.host_drop, 0);
        chk("rst_dm_we_host", dm_we, 0);
        chk("pc_init", pc_init, 0);
        step();
        step();
        RST_N = 1'b1;

        bus.start = 1'b1;
        bus.host_we = 1'b1;
        bus.host_addr = 8'h08;
        bus.host_wdata = 8'h00;
        #1;
        chk("idle_dm_we", dm_we, 1);
        chk("idle_dm_addr", dm_addr, 8'h08);
        step();
        chk("load_pc_load", pc_load, 1);
        chk("load_core_en", core_en, 0);
        chk("load_halt", bus.halt, 0);
        bus.host_addr = 8'h09;
        bus.host_wdata = 8'hFF;
        #1;
        chk("load_dm_addr", dm_addr, 8'h09);
        chk("load_dm_wdata", dm_wdata, 8'hFF);
        step();
        bus.host_addr = 8'h02;
        bus.host_wdata = 8'hA5;
        step();
        bus.host_we = 1'b0;
        #1;
        chk("load_dm_we_off", dm_we, 0);
        chk("mem8", mem[8], 8'h00);
        chk("mem9", mem[9], 8'hFF);
        chk("mem2_pre", mem[2], 8'hA5);

        bus.start = 1'b0;
        core_we = 1'b0;
        core_addr = 8'h20;
        step();
        chk("run_core_en", core_en, 1);
        chk("run_pc_load", pc_load, 0);
        chk("run_cycles0", run_cycles, 0);
        en_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (core_en) en_cnt++;
            if (k == 10) begin
                bus.host_we = 1'b1;
                bus.host_addr = 8'h02;
                bus.host_wdata = 8'h11;
                #1;
                chk("run_dm_we_masked", dm_we, 0);
                chk("run_dm_addr_core", dm_addr, 8'h20);
            end
            if (k == 11) begin
                chk("drop_pulse", bus.host_drop, 1);
                bus.host_we = 1'b0;
            end
            if (k == 12) chk("drop_clear", bus.host_drop, 0);
            if (k == 20) begin
                core_we = 1'b1;
                core_addr = 8'h0B;
                core_wdata = 8'h77;
                #1;
                chk("run_dm_we_core", dm_we, 1);
            end
            if (k == 21) core_we = 1'b0;
            if (k == 40) begin
                halt_instr = 1'b1;
                core_we = 1'b1;
                core_addr = 8'h0A;
                core_wdata = 8'h3C;
            end
            step();
        end
        halt_instr = 1'b0;
        core_we = 1'b0;
        chk("en_cnt", en_cnt, 40);
        chk("done_halt", bus.halt, 1);
        chk("done_core_en", core_en, 0);
        chk("done_cycles", run_cycles, 40);
        chk("halt_write_commit", mem[10], 8'h3C);
        chk("mem11", mem[11], 8'h77);
        chk("mem2_kept", mem[2], 8'hA5);
        bus.host_addr = 8'h0A;
        #1;
        chk("done_host_addr", dm_addr, 8'h0A);
        step();
        chk("done_halt_level", bus.halt, 1);
        chk("done_cycles_frozen", run_cycles, 40);

        bus.start = 1'b1;
        step();
        chk("restart_halt", bus.halt, 0);
        chk("restart_cycles", run_cycles, 0);
        bus.start = 1'b0;
        step();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) halt_instr = 1'b1;
            step();
        end
        halt_instr = 1'b0;
        chk("job2_halt", bus.halt, 1);
        chk("job2_cycles", run_cycles, 5);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        chk("job3_cycles", run_cycles, 2);
        bus.start = 1'b1;
        halt_instr = 1'b1;
        step();
        chk("abort_halt", bus.halt, 0);
        chk("abort_pc_load", pc_load, 1);
        chk("abort_core_en", core_en, 0);
        chk("abort_cycles", run_cycles, 0);
        bus.start = 1'b0;
        halt_instr = 1'b0;
        step();
        chk("glitch_run", core_en, 1);
        step();
        core_we = 1'b1;
        core_addr = 8'h05;
        #1;
        chk("pre_rst_dm_we", dm_we, 1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_core_en", core_en, 0);
        chk("async_pc_load", pc_load, 1);
        chk("async_dm_we", dm_we, 0);
        chk("async_cycles", run_cycles, 0);
        core_we = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        chk("post_rst_idle", core_en, 0);

`ifdef RUN_CTRL_WATCHDOG_EN
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int k = 1; k <= 99; k++) step();
        chk("wd_pre_halt", bus.halt, 0);
        chk("wd_pre_cycles", run_cycles, 99);
        step();
        chk("wd_halt", bus.halt, 1);
        chk("wd_timeout", timeout, 1);
        chk("wd_cycles", run_cycles, 100);
        bus.start = 1'b1;
        step();
        chk("wd_timeout_clr", timeout, 0);
        bus.start = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
